// File: rtl/sram_sync_param.sv
// sram_sync_param: parametrised synchronous single-port SRAM with a
// registered read port, a one-cycle data_valid strobe and a hardware clear
// sweep that fills every word with INIT_VALUE after reset or on request.
//
// Optional build macro: SRAM_PARITY_EN
//   defined   - each word carries an even-parity bit (array "par"), checked
//               on every read and reported through parity_err
//   undefined - no parity storage, parity_err tied low
// The port list is identical in both builds.

module sram_sync_param #(
  parameter int unsigned DATA_WIDTH = 4,
  parameter int unsigned ADDR_WIDTH = 2,
  parameter int unsigned INIT_VALUE = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  operation,
  input  logic [ADDR_WIDTH-1:0] select,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  clear,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  busy,
  output logic                  parity_err
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  // Fill word for the clear sweep, truncated to the word width.
  localparam logic [DATA_WIDTH-1:0] INIT_WORD = DATA_WIDTH'(INIT_VALUE);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic [ADDR_WIDTH-1:0]   counter;
  logic [ADDR_WIDTH-1:0]   counter_next;

  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_waddr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic                    rd_en;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  // State register and sweep counter; reset parks the FSM in CLEAR at address 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= CLEAR;
      counter <= '0;
    end else begin
      state   <= state_next;
      counter <= counter_next;
    end
  end

  // Next-state, sweep counter and memory write/read request decode.
  // clear in READY wins over any same-cycle request, which is dropped.
  always_comb begin
    state_next   = state;
    counter_next = counter;
    mem_we       = 1'b0;
    mem_waddr    = select;
    mem_wdata    = data_in;
    rd_en        = 1'b0;
    unique case (state)
      CLEAR: begin
        mem_we       = 1'b1;
        mem_waddr    = counter;
        mem_wdata    = INIT_WORD;
        counter_next = counter + 1'b1;
        if (counter == LAST_ADDR) begin
          state_next = READY;
        end
      end
      READY: begin
        if (clear) begin
          state_next   = CLEAR;
          counter_next = '0;
        end else if (enable) begin
          if (operation) begin
            rd_en = 1'b1;
          end else begin
            mem_we = 1'b1;
          end
        end
      end
      default: begin
        state_next   = CLEAR;
        counter_next = '0;
      end
    endcase
  end

  assign busy = (state == CLEAR);

  // Storage array; contents are not touched by reset, only by the sweep.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Registered read port; data_out holds its last value between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out   <= '0;
      data_valid <= 1'b0;
    end else if (rd_en) begin
      data_out   <= mem[select];
      data_valid <= 1'b1;
    end else begin
      data_valid <= 1'b0;
    end
  end

`ifdef SRAM_PARITY_EN
  logic par [DEPTH];

  // Parity side array written alongside the data array with even parity.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      par[mem_waddr] <= ^mem_wdata;
    end
  end

  // Parity check registered with the read data; low on non-read cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_err <= 1'b0;
    end else if (rd_en) begin
      parity_err <= (par[select] != (^mem[select]));
    end else begin
      parity_err <= 1'b0;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_sram_sync_param.sv
// Directed self-checking bench for sram_sync_param. Two instances share all
// inputs: one with INIT_VALUE=0, one with INIT_VALUE=9, so the clear fill
// value is visible. Parity checks are compiled in with SRAM_PARITY_EN.

module tb_sram_sync_param;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       operation;
  logic [1:0] select;
  logic [3:0] data_in;
  logic       clear;

  logic [3:0] data_out,  data_out9;
  logic       data_valid, data_valid9;
  logic       busy, busy9;
  logic       parity_err, parity_err9;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  sram_sync_param #(.DATA_WIDTH(4), .ADDR_WIDTH(2), .INIT_VALUE(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .operation(operation),
    .select(select), .data_in(data_in), .clear(clear),
    .data_out(data_out), .data_valid(data_valid), .busy(busy),
    .parity_err(parity_err)
  );

  sram_sync_param #(.DATA_WIDTH(4), .ADDR_WIDTH(2), .INIT_VALUE(9)) u_dut9 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .operation(operation),
    .select(select), .data_in(data_in), .clear(clear),
    .data_out(data_out9), .data_valid(data_valid9), .busy(busy9),
    .parity_err(parity_err9)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    enable = 1'b0; operation = 1'b0; clear = 1'b0;
  endtask

  task automatic do_write(input logic [1:0] a, input logic [3:0] d);
    enable = 1'b1; operation = 1'b0; select = a; data_in = d;
    tick();
  endtask

  task automatic do_read(input logic [1:0] a);
    enable = 1'b1; operation = 1'b1; select = a;
    tick();
  endtask

  // Expects the sweep to have just started: busy for three more edges, then free.
  task automatic sweep_check(input string tag);
    for (int i = 0; i < 3; i++) begin
      tick();
      check({tag, "_busy"}, {7'd0, busy}, 8'd1);
    end
    tick();
    check({tag, "_done"}, {7'd0, busy}, 8'd0);
  endtask

  initial begin
    rst_n = 1'b0; select = '0; data_in = '0;
    idle();

    // Reset state
    tick(); tick();
    check("rst_dout",  {4'd0, data_out},  8'h00);
    check("rst_valid", {7'd0, data_valid}, 8'h00);
    check("rst_busy",  {7'd0, busy},       8'h01);
    check("rst_perr",  {7'd0, parity_err}, 8'h00);

    // Release: exactly 4 busy cycles, requests ignored meanwhile
    rst_n = 1'b1;
    enable = 1'b1; operation = 1'b1;
    check("rel_busy", {7'd0, busy}, 8'h01);
    sweep_check("sweep1");
    check("sweep1_noval", {7'd0, data_valid}, 8'h00);

    // Read all four addresses after the sweep
    for (int a = 0; a < 4; a++) begin
      do_read(2'(a));
      check($sformatf("init_rd%0d", a),  {4'd0, data_out},  8'h00);
      check($sformatf("init9_rd%0d", a), {4'd0, data_out9}, 8'h09);
      check($sformatf("init_val%0d", a), {7'd0, data_valid}, 8'h01);
    end
    idle(); tick();
    check("init_val_drop", {7'd0, data_valid}, 8'h00);

    // Consecutive writes, then back-to-back reads
    do_write(2'd0, 4'b1010);
    check("wr_noval", {7'd0, data_valid}, 8'h00);
    check("wr_hold",  {4'd0, data_out},  8'h00);
    do_write(2'd1, 4'b1100);
    do_write(2'd2, 4'b0110);
    do_write(2'd3, 4'b0011);
    do_read(2'd0);
    check("b2b_rd0", {4'd0, data_out}, 8'h0a);
    check("b2b_v0",  {7'd0, data_valid}, 8'h01);
    do_read(2'd1);
    check("b2b_rd1", {4'd0, data_out}, 8'h0c);
    check("b2b_v1",  {7'd0, data_valid}, 8'h01);
    do_read(2'd2);
    check("b2b_rd2", {4'd0, data_out}, 8'h06);
    check("b2b_v2",  {7'd0, data_valid}, 8'h01);
    do_read(2'd3);
    check("b2b_rd3", {4'd0, data_out}, 8'h03);
    check("b2b_v3",  {7'd0, data_valid}, 8'h01);
    check("b2b_perr", {7'd0, parity_err}, 8'h00);

    // Read-after-write, then hold with enable low
    do_write(2'd1, 4'b1111);
    do_read(2'd1);
    check("raw_rd", {4'd0, data_out}, 8'h0f);
    idle();
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("hold_dout%0d", i), {4'd0, data_out}, 8'h0f);
      check($sformatf("hold_val%0d", i),  {7'd0, data_valid}, 8'h00);
    end

    // clear together with a write: write dropped, sweep runs
    enable = 1'b1; operation = 1'b0; select = 2'd2; data_in = 4'b0101; clear = 1'b1;
    tick();
    check("clr_busy0", {7'd0, busy}, 8'h01);
    clear = 1'b0; enable = 1'b1; operation = 1'b1; select = 2'd0;
    sweep_check("sweep2");
    check("clr_noval", {7'd0, data_valid}, 8'h00);
    check("clr_hold",  {4'd0, data_out},  8'h0f);
    do_read(2'd2);
    check("clr_rd2",  {4'd0, data_out},  8'h00);
    check("clr9_rd2", {4'd0, data_out9}, 8'h09);
    do_read(2'd1);
    check("clr_rd1",  {4'd0, data_out},  8'h00);
    check("clr9_rd1", {4'd0, data_out9}, 8'h09);
    idle(); tick();

    // Reset in the 2nd cycle of a sweep
    clear = 1'b1; tick();
    clear = 1'b0; tick();
    check("mid_busy", {7'd0, busy}, 8'h01);
    rst_n = 1'b0; #1;
    check("mid_rst_dout9", {4'd0, data_out9}, 8'h00);
    check("mid_rst_busy",  {7'd0, busy}, 8'h01);
    tick();
    rst_n = 1'b1;
    sweep_check("sweep3");

    // Reset during a read cycle
    do_write(2'd0, 4'b1010);
    do_read(2'd0);
    check("pre_rst_rd", {4'd0, data_out}, 8'h0a);
    #2 rst_n = 1'b0; #1;
    check("rd_rst_dout",  {4'd0, data_out},   8'h00);
    check("rd_rst_valid", {7'd0, data_valid}, 8'h00);
    check("rd_rst_busy",  {7'd0, busy},       8'h01);
    idle();
    tick();
    rst_n = 1'b1;
    sweep_check("sweep4");
    do_read(2'd0);
    check("post_rst_rd9", {4'd0, data_out9}, 8'h09);
    idle(); tick();

`ifdef SRAM_PARITY_EN
    // Corrupted parity bit is flagged for exactly one read
    do_write(2'd3, 4'b0110);
    idle(); tick();
    u_dut.par[3] = ~u_dut.par[3];
    do_read(2'd3);
    check("par_dout", {4'd0, data_out},   8'h06);
    check("par_err",  {7'd0, parity_err}, 8'h01);
    do_read(2'd0);
    check("par_ok0",  {7'd0, parity_err}, 8'h00);
    check("par9_ok0", {7'd0, parity_err9}, 8'h00);
    idle(); tick();
    check("par_idle", {7'd0, parity_err}, 8'h00);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
